// File: rtl/fx2_emu_pkg.sv
// fx2_emu_pkg: strobe polarity, FIFO-select encodings and width helper for the FX2 slave-FIFO emulator
package fx2_emu_pkg;
  localparam logic FX2_STROBE_ACT = 1'b0;
  localparam logic FIFOSEL_EP2 = 1'b0;
  localparam logic FIFOSEL_EP6 = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fx2_emu_fifo.sv
// fx2_emu_fifo: synchronous first-word-fall-through byte FIFO with occupancy count
module fx2_emu_fifo
  import fx2_emu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [7:0]          din_i,
  input  logic                pop_i,
  output logic [7:0]          dout_o,
  output logic [DEPTH_LOG2:0] cnt_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [7:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH_LOG2:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign do_push = push_i && cnt_q != (DEPTH_LOG2+1)'(DEPTH);
  assign do_pop = pop_i && cnt_q != '0;
  assign wp_d = wp_q + DEPTH_LOG2'(do_push);
  assign rp_d = rp_q + DEPTH_LOG2'(do_pop);
  assign cnt_d = cnt_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
  // An empty FIFO presents 0x00 so the head is defined straight out of reset.
  assign dout_o = cnt_q == '0 ? 8'h00 : mem[rp_q];
  assign cnt_o = cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wp_q] <= din_i;
  end
endmodule

// File: rtl/fx2_slave_fifo_emu.sv
// fx2_slave_fifo_emu: FX2 slave-FIFO peer with EP2 OUT and packet-committed EP6 IN FIFOs
module fx2_slave_fifo_emu
  import fx2_emu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int PKT_SIZE = 512
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       fx2FifoSel_in,
  output logic [7:0] fx2Data_out,
  input  logic [7:0] fx2Data_in,
  input  logic       fx2Read_in,
  output logic       fx2GotData_out,
  input  logic       fx2Write_in,
  output logic       fx2GotRoom_out,
  input  logic       fx2PktEnd_in,
  input  logic [7:0] hostTxData_in,
  input  logic       hostTxValid_in,
  output logic       hostTxReady_out,
  output logic [7:0] hostRxData_out,
  output logic       hostRxValid_out,
  input  logic       hostRxReady_in,
  output logic       hostRxZlp_out,
  output logic       ovfErr_out,
  output logic       udfErr_out
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = clog2(DEPTH + 1);
  logic [CW-1:0] ep2_cnt, ep6_cnt, ucnt_q, ucnt_d, ccnt_q, ccnt_d, uinc;
  logic ep2_sel, ep6_sel, ep2_full, ep6_full, rd, wr, pe;
  logic tx_push, ep2_pop, ep6_push, rx_pop, commit;
  logic zlp_q, zlp_d, ovf_q, ovf_d, udf_q, udf_d;
  assign ep2_sel = fx2FifoSel_in == FIFOSEL_EP2;
  assign ep6_sel = fx2FifoSel_in == FIFOSEL_EP6;
  assign ep2_full = ep2_cnt == CW'(DEPTH);
  assign ep6_full = ep6_cnt == CW'(DEPTH);
  assign rd = ep2_sel && fx2Read_in == FX2_STROBE_ACT;
  assign wr = ep6_sel && fx2Write_in == FX2_STROBE_ACT;
  assign pe = ep6_sel && fx2PktEnd_in == FX2_STROBE_ACT;
  assign tx_push = hostTxValid_in && !ep2_full;
  assign ep2_pop = rd && ep2_cnt != '0;
  assign ep6_push = wr && !ep6_full;
  assign rx_pop = hostRxValid_out && hostRxReady_in;
  assign fx2GotData_out = ep2_sel && ep2_cnt != '0;
  assign fx2GotRoom_out = ep6_sel && !ep6_full;
  assign hostTxReady_out = !ep2_full;
  assign hostRxValid_out = ccnt_q != '0;
  assign hostRxZlp_out = zlp_q;
  assign ovfErr_out = ovf_q;
  assign udfErr_out = udf_q;
  fx2_emu_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_ep2 (
    .clk_i(clk_in), .rst_ni(reset_in), .push_i(tx_push), .din_i(hostTxData_in),
    .pop_i(ep2_pop), .dout_o(fx2Data_out), .cnt_o(ep2_cnt)
  );
  fx2_emu_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_ep6 (
    .clk_i(clk_in), .rst_ni(reset_in), .push_i(ep6_push), .din_i(fx2Data_in),
    .pop_i(rx_pop), .dout_o(hostRxData_out), .cnt_o(ep6_cnt)
  );
  // A push landing in the same cycle as PktEnd is folded into that commit.
  always_comb begin
    uinc = ucnt_q + CW'(ep6_push);
    commit = (ep6_push && uinc == CW'(PKT_SIZE)) || (pe && uinc != '0);
    ucnt_d = commit ? '0 : uinc;
    ccnt_d = ccnt_q - CW'(rx_pop) + (commit ? uinc : '0);
    zlp_d = pe && ucnt_q == '0 && !ep6_push;
    ovf_d = ovf_q || (wr && ep6_full);
    udf_d = udf_q || (rd && ep2_cnt == '0);
  end
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      ucnt_q <= '0;
      ccnt_q <= '0;
      zlp_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ucnt_q <= ucnt_d;
      ccnt_q <= ccnt_d;
      zlp_q <= zlp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
endmodule
